// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, read FSM encoding and byte-lane merge helper
// for the register responder.
package axi_lite_pkg;

    localparam int          RESP_W      = 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam int          BUS_W  = 32;
    localparam int          STRB_W = BUS_W / 8;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [BUS_W-1:0] apply_wstrb(
        input logic [BUS_W-1:0]  old_val,
        input logic [BUS_W-1:0]  new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [BUS_W-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_responder_if.sv
// AXI4-Lite bus bundle between a master and the register responder.
interface axi_lite_reg_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi_lite_wr_buf.sv
// One-entry holding register for an AXI valid/ready channel; ready is a
// registered "buffer empty" flag, the entry is released by clear_i.
module axi_lite_wr_buf #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         ready_o,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q,  full_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data_q,  data_d;

    // Next-state: release on clear, capture on handshake.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && ready_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else begin
            full_d = full_q;
        end
        ready_d = ~full_d;
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers plus one read-only
// status word; register contents are exported flat on regs_o.
module axi_lite_reg_responder
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 12
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    axi_lite_reg_responder_if.slave      s_axi,
    input  logic [DATA_W-1:0]            status_i,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int               IDX_W   = OFFSET_W - 2;
    localparam int               STRB_WD = DATA_W / 8;
    localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_REGS);

    logic                  aw_ready_s, aw_full_s;
    logic [ADDR_W-1:0]     aw_addr_s;
    logic                  w_ready_s, w_full_s;
    logic [DATA_W-1:0]     w_data_s;
    logic [STRB_WD-1:0]    w_strb_s;
    logic                  commit_s;
    logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
    logic [1:0]            wr_resp_s;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];

    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q,  bresp_d;

    rd_state_e             state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [DATA_W-1:0]     rd_data_s;
    logic [1:0]            rd_resp_s;
    logic                  ar_hs_s;
    logic                  unused_s;

    axi_lite_wr_buf #(.W(ADDR_W)) u_aw_buf (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (s_axi.AWVALID),
        .data_i  (s_axi.AWADDR),
        .clear_i (commit_s),
        .ready_o (aw_ready_s),
        .full_o  (aw_full_s),
        .data_o  (aw_addr_s)
    );

    axi_lite_wr_buf #(.W(DATA_W + STRB_WD)) u_w_buf (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (s_axi.WVALID),
        .data_i  ({s_axi.WSTRB, s_axi.WDATA}),
        .clear_i (commit_s),
        .ready_o (w_ready_s),
        .full_o  (w_full_s),
        .data_o  ({w_strb_s, w_data_s})
    );

    // A held response blocks the next commit until the master takes it.
    assign commit_s  = aw_full_s && w_full_s && (!bvalid_q || s_axi.BREADY);
    assign wr_idx_s  = aw_addr_s[OFFSET_W-1:2];
    assign rd_idx_s  = s_axi.ARADDR[OFFSET_W-1:2];
    assign wr_resp_s = (wr_idx_s < NUM_IDX) ? RESP_OKAY : RESP_SLVERR;
    assign ar_hs_s   = s_axi.ARVALID && arready_q;

    assign unused_s = ^{s_axi.AWPROT, s_axi.ARPROT,
                        aw_addr_s[ADDR_W-1:OFFSET_W], aw_addr_s[1:0],
                        s_axi.ARADDR[ADDR_W-1:OFFSET_W], s_axi.ARADDR[1:0]};

    // Register bank next-state with byte-lane merge on commit.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_s && (wr_idx_s == IDX_W'(k))) begin
                regs_d[k] = apply_wstrb(regs_q[k], w_data_s, w_strb_s);
            end else begin
                regs_d[k] = regs_q[k];
            end
        end
    end

    // Write response next-state.
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp_s;
        end else if (s_axi.BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
    end

    // Read decode from the current (pre-commit) register values.
    always_comb begin
        rd_data_s = '0;
        rd_resp_s = RESP_SLVERR;
        if (rd_idx_s < NUM_IDX) begin
            rd_resp_s = RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (rd_idx_s == IDX_W'(k)) begin
                    rd_data_s = regs_q[k];
                end else begin
                    rd_data_s = rd_data_s;
                end
            end
        end else if (rd_idx_s == NUM_IDX) begin
            rd_data_s = status_i;
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Read FSM next-state and registered channel outputs.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    state_d = R_DATA;
                    rdata_d = rd_data_s;
                    rresp_d = rd_resp_s;
                end else begin
                    state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi.RREADY) begin
                    state_d = R_IDLE;
                end else begin
                    state_d = R_DATA;
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
        arready_d = (state_d == R_IDLE);
        rvalid_d  = (state_d == R_DATA);
    end

    // All state registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            state_q   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign s_axi.AWREADY = aw_ready_s;
    assign s_axi.WREADY  = w_ready_s;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Scoreboard bench for axi_lite_reg_responder: tasks queue expected B/R
// responses, a negedge monitor pops and compares on each handshake.
module tb_axi_lite_reg_responder;
    import axi_lite_pkg::*;

    localparam int NREG = 4;

    logic               clk = 1'b0;
    logic               areset;
    logic [31:0]        status;
    logic [NREG*32-1:0] regs_o;

    int errors = 0;
    int checks = 0;
    int b_done = 0;
    int r_done = 0;

    logic [1:0]  exp_b_q [$];
    logic [31:0] exp_rd_q [$];
    logic [1:0]  exp_rr_q [$];

    axi_lite_reg_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_reg_responder #(
        .NUM_REGS (NREG),
        .DATA_W   (32),
        .ADDR_W   (32),
        .OFFSET_W (12)
    ) dut (
        .ACLK     (clk),
        .ARESET   (areset),
        .s_axi    (bus),
        .status_i (status),
        .regs_o   (regs_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every B and R handshake against the scoreboard.
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [31:0] ed;
        logic [1:0]  er;
        if (!areset && bus.BVALID && bus.BREADY) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got BRESP %h expected no response", bus.BRESP);
            end else begin
                eb = exp_b_q.pop_front();
                chk("bresp", {30'd0, bus.BRESP}, {30'd0, eb});
            end
            b_done++;
        end
        if (!areset && bus.RVALID && bus.RREADY) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got RDATA %h expected no response", bus.RDATA);
            end else begin
                ed = exp_rd_q.pop_front();
                er = exp_rr_q.pop_front();
                chk("rdata", bus.RDATA, ed);
                chk("rresp", {30'd0, bus.RRESP}, {30'd0, er});
            end
            r_done++;
        end
    end

    task automatic wait_b(input int target);
        for (int i = 0; i < 40 && b_done < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk("b_timeout", {31'd0, b_done >= target}, 32'd1);
    endtask

    task automatic wait_r(input int target);
        for (int i = 0; i < 40 && r_done < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk("r_timeout", {31'd0, r_done >= target}, 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp,
                             input bit wait_resp);
        int  prev;
        bit  aw_done, w_done, aw_hs, w_hs;
        prev    = b_done;
        aw_done = 1'b0;
        w_done  = 1'b0;
        exp_b_q.push_back(resp);
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        bus.WDATA   = data;
        bus.WSTRB   = strb;
        bus.WVALID  = 1'b1;
        for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge clk);
            #1;
            if (aw_hs) begin
                bus.AWVALID = 1'b0;
                aw_done     = 1'b1;
            end
            if (w_hs) begin
                bus.WVALID = 1'b0;
                w_done     = 1'b1;
            end
        end
        chk("aw_w_timeout", {31'd0, aw_done && w_done}, 32'd1);
        if (wait_resp) begin
            wait_b(prev + 1);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input bit wait_resp);
        int prev;
        bit ar_done, ar_hs;
        prev    = r_done;
        ar_done = 1'b0;
        exp_rd_q.push_back(data);
        exp_rr_q.push_back(resp);
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        for (int i = 0; i < 40 && !ar_done; i++) begin
            @(negedge clk);
            ar_hs = bus.ARVALID && bus.ARREADY;
            @(posedge clk);
            #1;
            if (ar_hs) begin
                bus.ARVALID = 1'b0;
                ar_done     = 1'b1;
            end
        end
        chk("ar_timeout", {31'd0, ar_done}, 32'd1);
        if (wait_resp) begin
            wait_r(prev + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]        wdat [4];
        logic [NREG*32-1:0] snap;
        int                 prev;
        wdat[0] = 32'h0101FFFF;
        wdat[1] = 32'hABCD0001;
        wdat[2] = 32'hDEAD0011;
        wdat[3] = 32'hBEEF0011;

        areset = 1'b1;
        status = 32'h0;
        bus.AWADDR = 32'h0; bus.AWPROT = 3'd0; bus.AWVALID = 1'b0;
        bus.WDATA = 32'h0;  bus.WSTRB = 4'h0;  bus.WVALID = 1'b0;
        bus.BREADY = 1'b1;
        bus.ARADDR = 32'h0; bus.ARPROT = 3'd0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
        chk("rst_wready",  {31'd0, bus.WREADY},  32'd0);
        chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
        chk("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, bus.RVALID},  32'd0);
        chk("rst_rdata",   bus.RDATA, 32'h0);
        chk("rst_regs_lo", regs_o[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        chk("rst_regs_hi", regs_o[127:64] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Full-word writes with read-back to each register.
        for (int k = 0; k < NREG; k++) begin
            axi_write(32'(k * 4), wdat[k], 4'hF, RESP_OKAY, 1'b1);
            chk($sformatf("regs_o_%0d", k), regs_o[k*32 +: 32], wdat[k]);
            axi_read(32'(k * 4), wdat[k], RESP_OKAY, 1'b1);
        end

        // Byte strobes: lanes 0 and 2 only.
        axi_write(32'h0, 32'hFFFFFFFF, 4'hF, RESP_OKAY, 1'b1);
        axi_write(32'h0, 32'h12345678, 4'b0101, RESP_OKAY, 1'b1);
        axi_read(32'h0, 32'hFF34FF78, RESP_OKAY, 1'b1);
        axi_write(32'h0, 32'h00000000, 4'b0000, RESP_OKAY, 1'b1);
        axi_read(32'h0, 32'hFF34FF78, RESP_OKAY, 1'b1);

        // W three cycles ahead of AW; BVALID two cycles after the AW handshake.
        prev = b_done;
        exp_b_q.push_back(RESP_OKAY);
        bus.WDATA = 32'hCAFEF00D;
        bus.WSTRB = 4'hF;
        bus.WVALID = 1'b1;
        @(negedge clk);
        chk("w_first_wready", {31'd0, bus.WREADY}, 32'd1);
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("wready_low_held", {31'd0, bus.WREADY}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.AWADDR = 32'h4;
        bus.AWVALID = 1'b1;
        @(negedge clk);
        chk("late_awready", {31'd0, bus.AWREADY}, 32'd1);
        @(posedge clk);
        #1;
        bus.AWVALID = 1'b0;
        @(negedge clk);
        chk("bvalid_n1", {31'd0, bus.BVALID}, 32'd0);
        chk("reg1_n1", regs_o[63:32], 32'hABCD0001);
        @(negedge clk);
        chk("bvalid_n2", {31'd0, bus.BVALID}, 32'd1);
        chk("reg1_n2", regs_o[63:32], 32'hCAFEF00D);
        @(posedge clk);
        #1;
        wait_b(prev + 1);

        // Status word and out-of-range accesses.
        status = 32'hA5A5A5A5;
        axi_read(32'h10, 32'hA5A5A5A5, RESP_OKAY, 1'b1);
        snap = regs_o;
        axi_write(32'h10, 32'h11111111, 4'hF, RESP_SLVERR, 1'b1);
        chk("status_wr_noeffect", (regs_o == snap) ? 32'd1 : 32'd0, 32'd1);
        axi_read(32'h20, 32'h0, RESP_SLVERR, 1'b1);
        axi_write(32'h20, 32'h22222222, 4'hF, RESP_SLVERR, 1'b1);
        chk("oor_wr_noeffect", (regs_o == snap) ? 32'd1 : 32'd0, 32'd1);

        // Back-pressure on B: second write held until the first response is taken.
        bus.BREADY = 1'b0;
        axi_write(32'h20, 32'h33333333, 4'hF, RESP_SLVERR, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("bp_bvalid", {31'd0, bus.BVALID}, 32'd1);
                chk("bp_bresp", {30'd0, bus.BRESP}, {30'd0, RESP_SLVERR});
            end
        end
        @(posedge clk);
        #1;
        axi_write(32'h8, 32'h55AA55AA, 4'hF, RESP_OKAY, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_awready", {31'd0, bus.AWREADY}, 32'd0);
            chk("bp_wready", {31'd0, bus.WREADY}, 32'd0);
            chk("bp_reg2_held", regs_o[95:64], 32'hDEAD0011);
        end
        @(posedge clk);
        #1;
        prev = b_done;
        bus.BREADY = 1'b1;
        wait_b(prev + 2);
        chk("bp_reg2_commit", regs_o[95:64], 32'h55AA55AA);

        // Reset with both responses pending.
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
        axi_write(32'h0, 32'h11112222, 4'hF, RESP_OKAY, 1'b0);
        axi_read(32'h4, 32'hCAFEF00D, RESP_OKAY, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_bvalid", {31'd0, bus.BVALID}, 32'd1);
        chk("pre_rst_rvalid", {31'd0, bus.RVALID}, 32'd1);
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("post_rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
        chk("post_rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
        chk("post_rst_regs", (regs_o == '0) ? 32'd1 : 32'd0, 32'd1);
        exp_b_q.delete();
        exp_rd_q.delete();
        exp_rr_q.delete();
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        @(posedge clk);
        #1;
        axi_write(32'hC, 32'h0BADCAFE, 4'hF, RESP_OKAY, 1'b1);
        axi_read(32'hC, 32'h0BADCAFE, RESP_OKAY, 1'b1);
        axi_read(32'h0, 32'h0, RESP_OKAY, 1'b1);

        chk("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
        chk("r_queue_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_responder.md
Name: axi_lite_reg_responder

Overview:
- Synthesizable AXI4-Lite slave (responder) presenting a bank of 32-bit read/write registers to the bus master.
- It is the target end for the master BFM write-then-read-back sequences run in the peripheral block-design benches.
- The register contents are exported flat to user logic, and a hardware status input is readable.
- It replaces ad-hoc per-peripheral slave decoders.

Parameters:
- NUM_REGS, 4, number of RW registers at word offsets 0..NUM_REGS-1 (2..64).
- DATA_W, 32, data bus width (fixed 32; WSTRB width DATA_W/8).
- ADDR_W, 32, address bus width.
- OFFSET_W, 12, low address bits decoded; upper bits ignored.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_W  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_W  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- status_i  in  DATA_W  hardware status, read-only at offset NUM_REGS.
- regs_o  out  NUM_REGS*DATA_W  register contents, reg k at bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (ARESET=1 at an edge): all registers 0, AWREADY=WREADY=ARREADY=0 during reset, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, holding buffers emptied. Outstanding transactions are dropped.
- Decode: idx = addr[OFFSET_W-1:2]; addr[1:0] ignored.
  - idx < NUM_REGS: RW register, response OKAY 2'b00.
  - idx == NUM_REGS: status_i, read-only. Writes return SLVERR with no effect; reads return OKAY.
  - idx > NUM_REGS: SLVERR 2'b10. Writes are discarded; reads return RDATA=0.
- Write path, AW and W accepted independently into one-entry holding buffers:
  - AWREADY=1 while the AW buffer is empty; WREADY=1 while the W buffer is empty; both are registered outputs.
  - AW before W, W before AW, and simultaneous arrival are all legal.
  - Commit fires on the edge where both buffers are full and (BVALID=0 or BREADY=1). The register updates per WSTRB byte lanes, BVALID=1 on the next cycle, and both buffers clear.
  - Minimum latency: AW and W handshake in cycle n, write visible on regs_o and BVALID=1 in cycle n+2.
  - BVALID holds, with BRESP stable, until BREADY. While a response is pending and unaccepted, no further commit occurs; the buffers stay full and their READYs stay low.
- Read path, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, capture RDATA/RRESP from current register values and go to R_DATA with RVALID=1 the next cycle.
  - R_DATA: ARREADY=0, RVALID=1, RDATA/RRESP stable. On RREADY, go to R_IDLE.
  - One read outstanding at most; read latency is 1 cycle after the AR handshake.
- Read/write collision on the same register at the same edge: the read returns the pre-write value.
- Read and write channels are fully concurrent; no write-over-read priority stalls are required.
- WSTRB=0 performs no register change but still returns OKAY.

Decomposition:
- Package axi_lite_pkg holds RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_W=2, and the read FSM state encoding.
- Optional sub-module axi_lite_wr_buf: one-entry valid/ready holding register, instantiated twice (AW, W).
- Register bank and read mux stay in the top.

Test Plan:
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read-back -> BRESP=RRESP=00, read data equals written data, regs_o slices match.
- Reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read returns 0xFF34FF78.
- W presented 3 cycles before AW at 0x4, data 0xCAFEF00D -> WREADY low after W accepted, BVALID 2 cycles after AW handshake, reg1=0xCAFEF00D.
- status_i=0xA5A5A5A5, read 0x10 -> 0xA5A5A5A5, OKAY. Write 0x10 -> SLVERR, no change. Read 0x20 -> RDATA=0, SLVERR. Write 0x20 -> SLVERR, regs_o unchanged.
- Hold BREADY=0 for 10 cycles, then issue a second AW/W -> BVALID/BRESP stable, second write held (AWREADY=WREADY=0), commits only after the first B handshake.
- Assert ARESET for 1 cycle while BVALID=1 and RVALID=1 -> both drop to 0 next cycle, regs_o=0, the next write/read completes normally.
